alu: RTL and testbench

//  32-bit integer ALU for the single-cycle/pipelined RISC-V datapath.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_comb.sv | 57 +++++
 rtl/alu.sv | 66 ++++++
 tb/tb_alu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_SLT    = 3'd4,
        ALU_SLTU   = 3'd5,
        ALU_XOR    = 3'd6,
        ALU_PASS_B = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result, zero/less-than flags and, with
// ALU_OVERFLOW_EN defined, signed overflow for ADD/SUB.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
`ifdef ALU_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             lt
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ltu;

    assign sum  = a + b;
    assign diff = a - b;
    assign lt   = $signed(a) < $signed(b);
    assign ltu  = a < b;

    always_comb begin
        res = '0;
        case (alu_op_e'(control))
            ALU_ADD:    res = sum;
            ALU_SUB:    res = diff;
            ALU_AND:    res = a & b;
            ALU_OR:     res = a | b;
            ALU_SLT:    res = {{(WIDTH-1){1'b0}}, lt};
            ALU_SLTU:   res = {{(WIDTH-1){1'b0}}, ltu};
            ALU_XOR:    res = a ^ b;
            ALU_PASS_B: res = b;
            default:    res = '0;
        endcase
    end

    assign zero = (res == '0);

`ifdef ALU_OVERFLOW_EN
    // Overflow only when the operand signs allow it and the result sign flips.
    always_comb begin
        ovf = 1'b0;
        case (alu_op_e'(control))
            ALU_ADD: ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
            ALU_SUB: ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu.sv
// Registered 32-bit RISC-V ALU: one op per clock, 1-cycle latency.
// Optional overflow output enabled by defining ALU_OVERFLOW_EN.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic [WIDTH-1:0] out,
    output logic             Zero,
    output logic             LessThan,
`ifdef ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] res;
    logic             zero_c;
    logic             lt_c;
`ifdef ALU_OVERFLOW_EN
    logic             ovf_c;
`endif

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a       (A),
        .b       (B),
        .control (control),
`ifdef ALU_OVERFLOW_EN
        .ovf     (ovf_c),
`endif
        .res     (res),
        .zero    (zero_c),
        .lt      (lt_c)
    );

    // Result/flags only load on a valid op; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            Zero     <= 1'b1;
            LessThan <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else if (in_valid) begin
            out      <= res;
            Zero     <= zero_c;
            LessThan <= lt_c;
`ifdef ALU_OVERFLOW_EN
            overflow <= ovf_c;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_valid <= 1'b0;
        else        out_valid <= in_valid;
    end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: per-cycle model comparison plus literal checks.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  control = '0;
    logic [31:0] out;
    logic        Zero;
    logic        LessThan;
    logic        out_valid;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int nvec = 0;
    int nerr = 0;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .control   (control),
        .out       (out),
        .Zero      (Zero),
        .LessThan  (LessThan),
`ifdef ALU_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec = nvec + 1;
        if (got !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: arithmetic done in 64-bit signed space, then truncated.
    function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        case (op)
            0: return 32'(sa + sb);
            1: return 32'(sa - sb);
            2: return a & b;
            3: return a | b;
            4: return (sa < sb) ? 32'd1 : 32'd0;
            5: return (ua < ub) ? 32'd1 : 32'd0;
            6: return a ^ b;
            default: return b;
        endcase
    endfunction

    function automatic logic ref_ovf(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        if (op == 0)      r = sa + sb;
        else if (op == 1) r = sa - sb;
        else              return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    logic [31:0] m_out = '0;
    logic        m_lt  = 1'b0;
    logic        m_vld = 1'b0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out <= '0; m_lt <= 1'b0; m_vld <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_vld <= in_valid;
            if (in_valid) begin
                m_out <= ref_res(int'(control), A, B);
                m_lt  <= $signed(A) < $signed(B);
                m_ovf <= ref_ovf(int'(control), A, B);
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_out", out, m_out);
        chk("cmp_zero", {31'b0, Zero}, {31'b0, m_out == 32'd0});
        chk("cmp_lt", {31'b0, LessThan}, {31'b0, m_lt});
        chk("cmp_vld", {31'b0, out_valid}, {31'b0, m_vld});
`ifdef ALU_OVERFLOW_EN
        chk("cmp_ovf", {31'b0, overflow}, {31'b0, m_ovf});
`endif
    end

    // Apply one valid op; returns just after the edge that registers it.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        in_valid = 1'b1; control = op; A = a; B = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } vec_t;
    vec_t stream [10];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, 32'd0);
        chk("rst_zero", {31'b0, Zero}, 32'd1);
        chk("rst_lt", {31'b0, LessThan}, 32'd0);
        chk("rst_vld", {31'b0, out_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        drive(3'd0, 32'd31, 32'd5);
        chk("add_out", out, 32'd36);
        chk("add_zero", {31'b0, Zero}, 32'd0);
        chk("add_lt", {31'b0, LessThan}, 32'd0);
        chk("add_vld", {31'b0, out_valid}, 32'd1);
        drive(3'd1, 32'd4, 32'd6);
        chk("sub_out", out, 32'hFFFFFFFE);
        chk("sub_lt", {31'b0, LessThan}, 32'd1);
        drive(3'd1, 32'd27, 32'd27);
        chk("sub0_out", out, 32'd0);
        chk("sub0_zero", {31'b0, Zero}, 32'd1);
        drive(3'd2, 32'd27, 32'd27);
        chk("and_out", out, 32'd27);
        drive(3'd3, 32'd1, 32'd2);
        chk("or_out", out, 32'd3);
        drive(3'd6, 32'd0, 32'd1);
        chk("xor_out", out, 32'd1);
        chk("xor_lt", {31'b0, LessThan}, 32'd1);
        drive(3'd7, 32'd0, 32'h12345000);
        chk("passb_out", out, 32'h12345000);
        drive(3'd4, 32'd37, -32'sd225);
        chk("slt_out", out, 32'd0);
        drive(3'd5, 32'd37, -32'sd225);
        chk("sltu_out", out, 32'd1);
        drive(3'd4, -32'sd225, 32'd37);
        chk("slt2_out", out, 32'd1);
        chk("slt2_lt", {31'b0, LessThan}, 32'd1);

`ifdef ALU_OVERFLOW_EN
        drive(3'd0, 32'h7FFFFFFF, 32'd1);
        chk("ovf_add_out", out, 32'h80000000);
        chk("ovf_add", {31'b0, overflow}, 32'd1);
        drive(3'd1, 32'h80000000, 32'd1);
        chk("ovf_sub", {31'b0, overflow}, 32'd1);
        drive(3'd2, 32'h80000000, 32'd1);
        chk("ovf_and", {31'b0, overflow}, 32'd0);
`endif

        // Hold, then asynchronous reset between edges.
        drive(3'd0, 32'd31, 32'd5);
        @(posedge clk); #1;
        chk("hold_out", out, 32'd36);
        chk("hold_vld", {31'b0, out_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", out, 32'd0);
        chk("arst_zero", {31'b0, Zero}, 32'd1);
        chk("arst_vld", {31'b0, out_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Back-to-back stream, one op per clock, checked by the model.
        stream[0] = '{3'd0, 32'hFFFFFFFF, 32'd1};
        stream[1] = '{3'd1, 32'd0, 32'd1};
        stream[2] = '{3'd4, 32'h80000000, 32'h7FFFFFFF};
        stream[3] = '{3'd5, 32'h80000000, 32'h7FFFFFFF};
        stream[4] = '{3'd6, 32'hA5A5A5A5, 32'hA5A5A5A5};
        stream[5] = '{3'd3, 32'hF0F00000, 32'h00000F0F};
        stream[6] = '{3'd2, 32'hFFFF0000, 32'h0000FFFF};
        stream[7] = '{3'd7, 32'hDEADBEEF, 32'd0};
        stream[8] = '{3'd0, 32'h80000000, 32'h80000000};
        stream[9] = '{3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i != 4);
            control = stream[i].op; A = stream[i].a; B = stream[i].b;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stream_last", out, 32'h80000000);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
